stopwatch_counter: RTL

Holds the stopwatch's minutes:seconds value, which the 7-segment display multiplexer renders on the four digits. Advances once per 1 Hz tick while running and wraps at 59:59. Supports run/pause toggling, synchronous clear and a manual adjust mode, in which the selected field steps at 2 Hz. Outputs are plain binary (0–59 per field), registered, and feed the display stage directly.

---
 rtl/stopwatch_counter_pkg.sv | 14 +
 rtl/stopwatch_counter_mod_counter.sv | 37 +++
 rtl/stopwatch_counter.sv | 94 +++++++++
 3 files changed

// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch minutes:seconds counter.
package stopwatch_counter_pkg;

  typedef enum logic [1:0] {
    StPaused = 2'd0,
    StRun    = 2'd1,
    StAdjust = 2'd2
  } sw_state_e;

  localparam int unsigned FieldW    = 8;
  localparam int unsigned DefMaxMin = 59;
  localparam int unsigned DefMaxSec = 59;

endpackage

// File: rtl/stopwatch_counter_mod_counter.sv
// Wrapping binary counter: 0..max_i, clear has priority over increment.
module mod_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic [Width-1:0] max_i,
  output logic [Width-1:0] value_o,
  output logic             carry_o
);

  logic [Width-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i) begin
      // Out-of-range values recover to 0 on the next step.
      value_d = (value_q >= max_i) ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = inc_i && (value_q == max_i);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch minutes:seconds counter with run/pause, clear and manual adjust.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned MAX_MIN = DefMaxMin,
  parameter int unsigned MAX_SEC = DefMaxSec
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              tick_2hz,
  input  logic              pause_btn,
  input  logic              clear_btn,
  input  logic              adj,
  input  logic              sel,
  output logic [FieldW-1:0] minutes,
  output logic [FieldW-1:0] seconds,
  output logic              running,
  output logic              adjusting,
  output logic              rollover
);

  sw_state_e state_q, state_d;
  logic      running_q, adjusting_q, rollover_q;
  logic      run_tick, adj_step;
  logic      sec_inc, min_inc;
  logic      sec_carry, min_carry;

  // Adjust steps only count while adj is still held; leaving adjust wins over a tick.
  assign run_tick = (state_q == StRun) && tick_1hz && !clear_btn;
  assign adj_step = (state_q == StAdjust) && adj && tick_2hz && !clear_btn;

  assign sec_inc = run_tick || (adj_step && sel);
  assign min_inc = (run_tick && sec_carry) || (adj_step && !sel);

  always_comb begin
    state_d = state_q;
    if (clear_btn) begin
      if (adj) state_d = StAdjust;
    end else if (adj) begin
      state_d = StAdjust;
    end else begin
      unique case (state_q)
        StPaused: if (pause_btn) state_d = StRun;
        StRun:    if (pause_btn) state_d = StPaused;
        StAdjust: state_d = StPaused;
        default:  state_d = StPaused;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPaused;
      running_q   <= 1'b0;
      adjusting_q <= 1'b0;
      rollover_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      running_q   <= (state_d == StRun);
      adjusting_q <= (state_d == StAdjust);
      rollover_q  <= run_tick && sec_carry && min_carry;
    end
  end

  mod_counter #(
    .Width (FieldW)
  ) u_sec (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (sec_inc),
    .clr_i   (clear_btn),
    .max_i   (FieldW'(MAX_SEC)),
    .value_o (seconds),
    .carry_o (sec_carry)
  );

  mod_counter #(
    .Width (FieldW)
  ) u_min (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (min_inc),
    .clr_i   (clear_btn),
    .max_i   (FieldW'(MAX_MIN)),
    .value_o (minutes),
    .carry_o (min_carry)
  );

  assign running   = running_q;
  assign adjusting = adjusting_q;
  assign rollover  = rollover_q;

endmodule
